// File: rtl/hamming_link_receiver.sv
// rtl/hamming_link_receiver.sv - serial Hamming(7,4) frame receiver with single-error correction
module hamming_link_receiver #(
  parameter int ABORT_GAP = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_line,
  input  logic             strobe,
  output logic [0:3]       msg_out,
  output logic             msg_valid,
  output logic             corrected,
  output logic [2:0]       err_pos,
  output logic             frame_abort,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam int GAP_W = $clog2(ABORT_GAP + 2);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_nxt;
  logic [5:0]       shreg, shreg_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [GAP_W-1:0] gapcnt, gapcnt_nxt;
  logic             done, abort_nxt;
  logic [7:1]       code, fixed;
  logic [2:0]       syn;

  // shreg[k-1] holds code bit k; bit 7 is taken straight from the line
  always_comb begin
    code   = {data_line, shreg};
    syn[0] = code[1] ^ code[3] ^ code[5] ^ code[7];
    syn[1] = code[2] ^ code[3] ^ code[6] ^ code[7];
    syn[2] = code[4] ^ code[5] ^ code[6] ^ code[7];
    fixed  = code;
    for (int i = 1; i <= 7; i++) begin
      fixed[i] = code[i] ^ (syn == 3'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    gapcnt_nxt = gapcnt;
    done       = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) begin
          shreg_nxt  = {5'b0, data_line};
          bitcnt_nxt = 3'd1;
          gapcnt_nxt = '0;
          state_nxt  = RECV;
        end
      end
      RECV: begin
        if (strobe) begin
          gapcnt_nxt = '0;
          if (bitcnt == 3'd6) begin
            done       = 1'b1;
            bitcnt_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            shreg_nxt[bitcnt] = data_line;
            bitcnt_nxt        = bitcnt + 3'd1;
          end
        end else if (gapcnt == GAP_W'(ABORT_GAP)) begin
          abort_nxt  = 1'b1;
          bitcnt_nxt = '0;
          gapcnt_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          gapcnt_nxt = gapcnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      gapcnt      <= '0;
      msg_out     <= '0;
      msg_valid   <= 1'b0;
      corrected   <= 1'b0;
      err_pos     <= '0;
      frame_abort <= 1'b0;
      frame_cnt   <= '0;
      corr_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bitcnt      <= bitcnt_nxt;
      gapcnt      <= gapcnt_nxt;
      msg_valid   <= done;
      corrected   <= done && (syn != 3'd0);
      frame_abort <= abort_nxt;
      if (done) begin
        msg_out <= {fixed[3], fixed[5], fixed[6], fixed[7]};
        err_pos <= syn;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
        if (syn != 3'd0 && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_link_receiver.sv
// tb/tb_hamming_link_receiver.sv - directed self-checking bench for hamming_link_receiver
module tb_hamming_link_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_line;
  logic       strobe;
  logic [0:3] msg_out, msg_out_s;
  logic       msg_valid, msg_valid_s;
  logic       corrected, corrected_s;
  logic [2:0] err_pos, err_pos_s;
  logic       frame_abort, frame_abort_s;
  logic [7:0] frame_cnt, corr_cnt;
  logic [1:0] frame_cnt_s, corr_cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_link_receiver #(.ABORT_GAP(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_line(data_line), .strobe(strobe),
    .msg_out(msg_out), .msg_valid(msg_valid), .corrected(corrected),
    .err_pos(err_pos), .frame_abort(frame_abort),
    .frame_cnt(frame_cnt), .corr_cnt(corr_cnt)
  );

  hamming_link_receiver #(.ABORT_GAP(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .data_line(data_line), .strobe(strobe),
    .msg_out(msg_out_s), .msg_valid(msg_valid_s), .corrected(corrected_s),
    .err_pos(err_pos_s), .frame_abort(frame_abort_s),
    .frame_cnt(frame_cnt_s), .corr_cnt(corr_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s);
    @(negedge clk);
    data_line = d;
    strobe    = s;
  endtask

  // code literal is written c1..c7 left to right
  task automatic send_frame(input logic [6:0] code);
    for (int i = 0; i < 7; i++) drive(code[6-i], 1'b1);
  endtask

  localparam logic [6:0] F1011     = 7'b0110011;
  localparam logic [6:0] F1011_E5  = 7'b0110111;
  localparam logic [6:0] F0000     = 7'b0000000;
  localparam logic [6:0] F0100_E6  = 7'b1001110;

  initial begin
    logic [6:0] f;
    rst = 1'b0; data_line = 1'b0; strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset msg_out", 32'(msg_out), 32'h0);
    chk("reset msg_valid", 32'(msg_valid), 32'h0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'h0);
    chk("reset err_pos", 32'(err_pos), 32'h0);
    rst = 1'b1;

    // clean frame
    send_frame(F1011);
    drive(1'b0, 1'b0);
    chk("clean valid", 32'(msg_valid), 32'h1);
    chk("clean msg", 32'(msg_out), 32'hB);
    chk("clean corrected", 32'(corrected), 32'h0);
    chk("clean err_pos", 32'(err_pos), 32'h0);
    chk("clean abort", 32'(frame_abort), 32'h0);
    drive(1'b0, 1'b0);
    chk("clean valid drop", 32'(msg_valid), 32'h0);
    chk("clean frame_cnt", 32'(frame_cnt), 32'h1);

    // single error at c5
    send_frame(F1011_E5);
    drive(1'b0, 1'b0);
    chk("err5 valid", 32'(msg_valid), 32'h1);
    chk("err5 msg", 32'(msg_out), 32'hB);
    chk("err5 corrected", 32'(corrected), 32'h1);
    chk("err5 err_pos", 32'(err_pos), 32'h5);
    drive(1'b0, 1'b0);
    chk("err5 corrected drop", 32'(corrected), 32'h0);
    chk("err5 err_pos hold", 32'(err_pos), 32'h5);
    chk("err5 corr_cnt", 32'(corr_cnt), 32'h1);
    chk("err5 frame_cnt", 32'(frame_cnt), 32'h2);

    // back-to-back frames with strobe held high
    send_frame(F1011);
    f = F0000;
    drive(f[6], 1'b1);
    chk("b2b first valid", 32'(msg_valid), 32'h1);
    chk("b2b first msg", 32'(msg_out), 32'hB);
    drive(f[5], 1'b1);
    chk("b2b valid gap", 32'(msg_valid), 32'h0);
    for (int i = 2; i < 7; i++) drive(f[6-i], 1'b1);
    drive(1'b0, 1'b0);
    chk("b2b second valid", 32'(msg_valid), 32'h1);
    chk("b2b second msg", 32'(msg_out), 32'h0);
    chk("b2b second err_pos", 32'(err_pos), 32'h0);
    drive(1'b0, 1'b0);
    chk("b2b frame_cnt", 32'(frame_cnt), 32'h4);

    // tolerated gap of ABORT_GAP cycles
    f = F1011;
    for (int i = 0; i < 3; i++) drive(f[6-i], 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(f[3], 1'b1);
    chk("gap2 no abort", 32'(frame_abort), 32'h0);
    for (int i = 4; i < 7; i++) drive(f[6-i], 1'b1);
    drive(1'b0, 1'b0);
    chk("gap2 valid", 32'(msg_valid), 32'h1);
    chk("gap2 msg", 32'(msg_out), 32'hB);

    // gap one longer aborts
    for (int i = 0; i < 3; i++) drive(f[6-i], 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("gap3 abort", 32'(frame_abort), 32'h1);
    chk("gap3 no valid", 32'(msg_valid), 32'h0);
    drive(1'b0, 1'b0);
    chk("gap3 abort drop", 32'(frame_abort), 32'h0);
    chk("gap3 frame_cnt", 32'(frame_cnt), 32'h5);
    chk("gap3 msg hold", 32'(msg_out), 32'hB);

    // frame after abort, error at c6, message 0100
    send_frame(F0100_E6);
    drive(1'b0, 1'b0);
    chk("post-abort valid", 32'(msg_valid), 32'h1);
    chk("post-abort msg", 32'(msg_out), 32'h4);
    chk("post-abort err_pos", 32'(err_pos), 32'h6);
    chk("post-abort corrected", 32'(corrected), 32'h1);
    drive(1'b0, 1'b0);
    chk("post-abort frame_cnt", 32'(frame_cnt), 32'h6);
    chk("post-abort corr_cnt", 32'(corr_cnt), 32'h2);
    chk("small frame_cnt sat", 32'(frame_cnt_s), 32'h3);

    // asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) drive(f[6-i], 1'b1);
    #2 rst = 1'b0;
    strobe = 1'b0;
    #1;
    chk("async rst msg_out", 32'(msg_out), 32'h0);
    chk("async rst err_pos", 32'(err_pos), 32'h0);
    chk("async rst frame_cnt", 32'(frame_cnt), 32'h0);
    chk("async rst corr_cnt", 32'(corr_cnt), 32'h0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("async rst no abort", 32'(frame_abort), 32'h0);
    rst = 1'b1;
    drive(1'b0, 1'b0);
    chk("post-rst no abort", 32'(frame_abort), 32'h0);
    send_frame(F1011);
    drive(1'b0, 1'b0);
    chk("post-rst valid", 32'(msg_valid), 32'h1);
    chk("post-rst msg", 32'(msg_out), 32'hB);
    drive(1'b0, 1'b0);
    chk("post-rst small cnt", 32'(frame_cnt_s), 32'h1);

    // saturation: four more clean frames, five since reset
    for (int n = 0; n < 4; n++) send_frame(F1011);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("sat frame_cnt wide", 32'(frame_cnt), 32'h5);
    chk("sat frame_cnt narrow", 32'(frame_cnt_s), 32'h3);
    chk("sat corr_cnt narrow", 32'(corr_cnt_s), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_link_receiver.md
Name: hamming_link_receiver

Overview:
- Downstream stage of the secure router: one instance per output lane, consuming that lane's serial data line and strobe.
- Deserialises 7-bit Hamming(7,4) frames and performs single-error correction.
- Presents the recovered 4-bit message with a one-cycle valid pulse and correction/abort status.

Parameters:
- ABORT_GAP, 2: maximum consecutive strobe-low cycles tolerated inside a frame; exceeding it aborts the frame.
- CNT_W, 8: width of the saturating frame and corrected-error counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_line  input  1  serial code bit; sampled only in cycles where strobe=1.
- strobe  input  1  bit-valid qualifier from the upstream sender.
- msg_out  output  [0:3]  decoded message, msg_out[0] = first data bit; holds until next valid frame.
- msg_valid  output  1  one-cycle pulse: msg_out updated.
- corrected  output  1  qualified by msg_valid: a single-bit error was corrected.
- err_pos  output  [2:0]  qualified by msg_valid: syndrome value (1..7 = corrected code position, 0 = clean).
- frame_abort  output  1  one-cycle pulse: partial frame discarded.
- frame_cnt  output  [CNT_W-1:0]  completed frames, saturating.
- corr_cnt  output  [CNT_W-1:0]  frames with corrected=1, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, shift register 0, bit counter 0, gap counter 0, FSM to IDLE. Any partial frame is discarded silently; no abort pulse.
- Frame format: code[1] first through code[7] last, one bit per strobe-high cycle.
  - Parity bits at code[1], code[2], code[4].
  - Data bits: code[3]=m0, code[5]=m1, code[6]=m2, code[7]=m3.
- Syndrome:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
  - err_pos = {s4,s2,s1}. A nonzero err_pos flips that code position before data extraction.
  - Double errors are miscorrected. This is accepted behaviour; no detection is required.
- FSM states:
  - IDLE: strobe=1 → capture bit 1, bitcnt=1, go to RECV. strobe=0 → stay.
  - RECV, strobe=1: capture bit, bitcnt++, gapcnt=0.
    - On capture of bit 7, decode from the 6 stored bits plus the current data_line, register the results, and return to IDLE.
  - RECV, strobe=0: gapcnt++.
    - If gapcnt would exceed ABORT_GAP: pulse frame_abort next cycle, clear bitcnt and gapcnt, go to IDLE.
- Latency: msg_valid, msg_out, corrected and err_pos update at the same clock edge that samples bit 7. They are visible in the cycle after the final strobe cycle.
  - msg_valid and corrected deassert after one cycle.
  - err_pos holds until the next valid frame.
- Back-to-back frames: strobe may stay high continuously. Bit 1 of the next frame is captured in the cycle immediately after bit 7, with no dead cycle. Throughput is one frame per 7 cycles.
- All-zero frames (idle router lanes) decode normally to msg 0000, valid, clean. They are not filtered.
- Counters: frame_cnt increments per msg_valid; corr_cnt increments per corrected. Both stop at all-ones. Aborted frames count in neither.
- Simultaneous events:
  - A strobe returning in the same cycle the gap limit is reached counts as a capture; the frame is not aborted.
  - Abort and valid can never coincide.

Test Plan:
- Clean frame: msg 1011 → serial 0110011 (c1..c7) on 7 consecutive strobes → msg_valid one cycle after bit 7, msg_out=1011, corrected=0, err_pos=0, frame_cnt=1.
- Single error: 0110111 (c5 flipped) → msg_out=1011, corrected=1, err_pos=5, corr_cnt=1.
- Back-to-back: 0110011 then 0000000 with strobe held high for 14 cycles → two msg_valid pulses 7 cycles apart with msg_out 1011 then 0000, frame_cnt=2.
- Gap handling with ABORT_GAP=2:
  - 3 bits, strobe low 2 cycles, then 4 bits → valid frame decoded.
  - 3 bits, strobe low 3 cycles → frame_abort pulse, no msg_valid, frame_cnt unchanged; the next full frame decodes correctly.
- Reset mid-frame: assert rst=0 after 4 bits → outputs 0 immediately (asynchronous), no abort pulse. After release, a full 0110011 frame → msg_out=1011.
- Saturation: with CNT_W=2, send 5 clean frames → frame_cnt stops at 3.
